mor1kx_rf_wrarb_marocchino: RTL and testbench

MOR1KX_RF_WRARB_MAROCCHINO -- requirements
Module: mor1kx_rf_wrarb_marocchino

---
 rtl/mor1kx_rf_wrarb_marocchino.sv | 151 +++++++++++++++
 tb/tb_mor1kx_rf_wrarb_marocchino.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_rf_wrarb_marocchino.sv
// Register-file write-port arbiter: WB writeback vs. GPR-space SPR accesses,
// with optional post-reset zero sweep of the RF (MOR1KX_RF_INIT_SWEEP_EN).
module mor1kx_rf_wrarb_marocchino #(
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_OPERAND_WIDTH     = 32,
  localparam int RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH +
    ((OPTION_RF_NUM_SHADOW_GPR == 1) ? 1 : $clog2(OPTION_RF_NUM_SHADOW_GPR))
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            spr_rd_en_o,
  output logic                            rf_busy_o
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WPEND, ST_RDACK, ST_GAP
  } state_t;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0]        adr;
    logic [OPTION_OPERAND_WIDTH-1:0] dat;
  } wr_req_t;

  state_t  state, nxt;
  wr_req_t hold, spr_req;
  logic    hold_ld;
  logic    gpr_req;

  assign gpr_req     = spr_bus_stb_i & (spr_bus_addr_i[15:9] == 7'h2);
  assign spr_req.adr = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign spr_req.dat = spr_bus_dat_i;

  // Address bits between the GPR index and the group field are don't-care.
  generate
    if (RF_ADDR_WIDTH < 9) begin : g_unused
      logic unused_adr;
      assign unused_adr = ^spr_bus_addr_i[8:RF_ADDR_WIDTH];
    end
  endgenerate

`ifdef MOR1KX_RF_INIT_SWEEP_EN
  logic [RF_ADDR_WIDTH-1:0] cnt;
  logic                     cnt_inc;
`endif

  always_comb begin
    nxt           = state;
    hold_ld       = 1'b0;
    spr_gpr_ack_o = 1'b0;
    rf_we_o       = 1'b0;
    rf_wradr_o    = '0;
    rf_wrdat_o    = '0;
    spr_rd_en_o   = 1'b0;
    rf_busy_o     = 1'b0;
`ifdef MOR1KX_RF_INIT_SWEEP_EN
    cnt_inc       = 1'b0;
`endif
    if (!rst) begin
      // WB owns the port whenever it strobes; everything else yields.
      if (wb_rf_we_i) begin
        rf_we_o    = 1'b1;
        rf_wradr_o = RF_ADDR_WIDTH'(wb_rfd_adr_i);
        rf_wrdat_o = wb_result_i;
      end
      case (state)
`ifdef MOR1KX_RF_INIT_SWEEP_EN
        ST_INIT: begin
          rf_busy_o = 1'b1;
          if (!wb_rf_we_i) begin
            rf_we_o    = 1'b1;
            rf_wradr_o = cnt;
            rf_wrdat_o = '0;
            cnt_inc    = 1'b1;
            if (cnt == {RF_ADDR_WIDTH{1'b1}})
              nxt = ST_IDLE;
          end
        end
`endif
        ST_IDLE: begin
          if (gpr_req) begin
            if (spr_bus_we_i) begin
              if (wb_rf_we_i) begin
                hold_ld = 1'b1;
                nxt     = ST_WPEND;
              end else begin
                rf_we_o       = 1'b1;
                rf_wradr_o    = spr_req.adr;
                rf_wrdat_o    = spr_req.dat;
                spr_gpr_ack_o = 1'b1;
                nxt           = ST_GAP;
              end
            end else if (!wb_rf_we_i) begin
              spr_rd_en_o = 1'b1;
              rf_wradr_o  = spr_req.adr;
              nxt         = ST_RDACK;
            end
          end
        end
        ST_WPEND: begin
          if (!wb_rf_we_i) begin
            rf_we_o       = 1'b1;
            rf_wradr_o    = hold.adr;
            rf_wrdat_o    = hold.dat;
            spr_gpr_ack_o = 1'b1;
            nxt           = ST_GAP;
          end
        end
        ST_RDACK: begin
          spr_gpr_ack_o = 1'b1;
          nxt           = ST_GAP;
        end
        // Strobe is still high in the ack-following cycle; skip it once.
        ST_GAP:  nxt = ST_IDLE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MOR1KX_RF_INIT_SWEEP_EN
      state <= ST_INIT;
      cnt   <= '0;
`else
      state <= ST_IDLE;
`endif
      hold  <= '0;
    end else begin
      state <= nxt;
      if (hold_ld)
        hold <= spr_req;
`ifdef MOR1KX_RF_INIT_SWEEP_EN
      if (cnt_inc)
        cnt <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mor1kx_rf_wrarb_marocchino.sv
// Bench for the RF write arbiter: per-cycle reference model plus directed
// literal checks; sweep checks are active when MOR1KX_RF_INIT_SWEEP_EN is set.
module tb_mor1kx_rf_wrarb_marocchino;

`ifdef MOR1KX_RF_INIT_SWEEP_EN
  localparam int SWEEP_LEN = 32;
`else
  localparam int SWEEP_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_rf_we_i = 1'b0;
  logic [4:0]  wb_rfd_adr_i = '0;
  logic [31:0] wb_result_i = '0;
  logic [15:0] spr_bus_addr_i = '0;
  logic        spr_bus_stb_i = 1'b0;
  logic        spr_bus_we_i = 1'b0;
  logic [31:0] spr_bus_dat_i = '0;
  logic        spr_gpr_ack_o, rf_we_o, spr_rd_en_o, rf_busy_o;
  logic [4:0]  rf_wradr_o;
  logic [31:0] rf_wrdat_o;

  int checks = 0;
  int errors = 0;

  mor1kx_rf_wrarb_marocchino dut (
    .clk(clk), .rst(rst),
    .wb_rf_we_i(wb_rf_we_i), .wb_rfd_adr_i(wb_rfd_adr_i), .wb_result_i(wb_result_i),
    .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o), .rf_we_o(rf_we_o), .rf_wradr_o(rf_wradr_o),
    .rf_wrdat_o(rf_wrdat_o), .spr_rd_en_o(spr_rd_en_o), .rf_busy_o(rf_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what is outstanding, not how the RTL encodes it.
  int          m_sweep = -1, n_sweep = -1;   // next sweep index, -1 when done
  bit          m_pend = 0, n_pend = 0;       // SPR write waiting for the port
  bit          m_rdack = 0, n_rdack = 0;     // read ack owed this cycle
  bit          m_gap = 0, n_gap = 0;         // held strobe to be ignored
  logic [4:0]  m_padr = '0, n_padr = '0;
  logic [31:0] m_pdat = '0, n_pdat = '0;

  always @(negedge clk) begin
    logic        e_we, e_ack, e_rd, e_busy, gpr;
    logic [4:0]  e_adr;
    logic [31:0] e_dat;
    e_we = 0; e_ack = 0; e_rd = 0; e_busy = 0; e_adr = '0; e_dat = '0;
    n_sweep = m_sweep; n_pend = m_pend; n_rdack = m_rdack; n_gap = m_gap;
    n_padr = m_padr; n_pdat = m_pdat;
    gpr = spr_bus_stb_i && (spr_bus_addr_i[15:9] == 7'h2);
    if (rst) begin
      n_sweep = (SWEEP_LEN > 0) ? 0 : -1;
      n_pend = 0; n_rdack = 0; n_gap = 0;
    end else begin
      if (wb_rf_we_i) begin
        e_we = 1; e_adr = wb_rfd_adr_i; e_dat = wb_result_i;
      end
      if (m_sweep >= 0) begin
        e_busy = 1;
        if (!wb_rf_we_i) begin
          e_we = 1; e_adr = m_sweep[4:0]; e_dat = 0;
          n_sweep = (m_sweep == SWEEP_LEN - 1) ? -1 : m_sweep + 1;
        end
      end else if (m_pend) begin
        if (!wb_rf_we_i) begin
          e_we = 1; e_adr = m_padr; e_dat = m_pdat; e_ack = 1;
          n_pend = 0; n_gap = 1;
        end
      end else if (m_rdack) begin
        e_ack = 1; n_rdack = 0; n_gap = 1;
      end else if (m_gap) begin
        n_gap = 0;
      end else if (gpr) begin
        if (spr_bus_we_i) begin
          if (wb_rf_we_i) begin
            n_pend = 1; n_padr = spr_bus_addr_i[4:0]; n_pdat = spr_bus_dat_i;
          end else begin
            e_we = 1; e_adr = spr_bus_addr_i[4:0]; e_dat = spr_bus_dat_i;
            e_ack = 1; n_gap = 1;
          end
        end else if (!wb_rf_we_i) begin
          e_rd = 1; e_adr = spr_bus_addr_i[4:0]; n_rdack = 1;
        end
      end
    end
    chk("model_we", rf_we_o, e_we);
    chk("model_ack", spr_gpr_ack_o, e_ack);
    chk("model_rd_en", spr_rd_en_o, e_rd);
    chk("model_busy", rf_busy_o, e_busy);
    if (e_we || e_rd) chk("model_adr", rf_wradr_o, e_adr);
    if (e_we) chk("model_dat", rf_wrdat_o, e_dat);
    chk("we_rd_exclusive", rf_we_o & spr_rd_en_o, 0);
  end

  always @(posedge clk) begin
    m_sweep <= n_sweep; m_pend <= n_pend; m_rdack <= n_rdack; m_gap <= n_gap;
    m_padr <= n_padr; m_pdat <= n_pdat;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    spr_bus_stb_i = 0; spr_bus_we_i = 0; spr_bus_addr_i = '0; spr_bus_dat_i = '0;
    wb_rf_we_i = 0;
  endtask

  // Pulse reset, then count busy cycles; ends at mid-cycle of first free cycle.
  task automatic do_reset(input bit chk_sweep);
    int n;
    tick(); rst = 1; bus_idle();
    #2;
    chk("rst_we", rf_we_o, 0);
    chk("rst_ack", spr_gpr_ack_o, 0);
    chk("rst_rd_en", spr_rd_en_o, 0);
    chk("rst_busy", rf_busy_o, 0);
    tick(); rst = 0;
    n = 0;
    #2;
    while (rf_busy_o && n < 100) begin
`ifdef MOR1KX_RF_INIT_SWEEP_EN
      if (chk_sweep) begin
        chk("sweep_we", rf_we_o, 1);
        chk("sweep_adr", rf_wradr_o, n);
        chk("sweep_dat", rf_wrdat_o, 0);
      end
`endif
      n++;
      tick(); #2;
    end
    chk("busy_len", n, SWEEP_LEN);
    chk("busy_low_after", rf_busy_o, 0);
    if (!chk_sweep) chk("free_no_write", rf_we_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1);

`ifdef MOR1KX_RF_INIT_SWEEP_EN
    // WB write steals sweep cycle 3; sweep resumes at 3, busy grows by one.
    begin
      int n;
      tick(); rst = 1;
      tick(); rst = 0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
        wb_rf_we_i = (c == 3); wb_rfd_adr_i = 5'd5; wb_result_i = 32'h5A5A_0005;
        #2;
        if (!rf_busy_o) break;
        if (c == 3) begin
          chk("sweep_wb_adr", rf_wradr_o, 5);
          chk("sweep_wb_dat", rf_wrdat_o, 32'h5A5A_0005);
        end
        if (c == 4) chk("sweep_resume_adr", rf_wradr_o, 3);
        n++;
        tick();
      end
      chk("busy_len_wb", n, 33);
    end
`endif

    // Plain SPR write in IDLE: same-cycle write and ack, strobe held into gap.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 1; spr_bus_addr_i = 16'h0405; spr_bus_dat_i = 32'hA5A5_0001;
    #2;
    chk("wr_we", rf_we_o, 1);
    chk("wr_adr", rf_wradr_o, 5);
    chk("wr_dat", rf_wrdat_o, 32'hA5A5_0001);
    chk("wr_ack", spr_gpr_ack_o, 1);
    tick(); #2;
    chk("wr_gap_ack", spr_gpr_ack_o, 0);
    chk("wr_gap_we", rf_we_o, 0);
    tick(); bus_idle();

    // SPR read 0x0410.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 0; spr_bus_addr_i = 16'h0410;
    #2;
    chk("rd_en", spr_rd_en_o, 1);
    chk("rd_adr", rf_wradr_o, 5'h10);
    chk("rd_ack0", spr_gpr_ack_o, 0);
    tick(); #2;
    chk("rd_ack1", spr_gpr_ack_o, 1);
    chk("rd_en1", spr_rd_en_o, 0);
    tick(); bus_idle(); #2;
    chk("rd_ack2", spr_gpr_ack_o, 0);

    // SPR write 0x0403 colliding with WB write to r7.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 1; spr_bus_addr_i = 16'h0403; spr_bus_dat_i = 32'hDEADBEEF;
    wb_rf_we_i = 1; wb_rfd_adr_i = 5'd7; wb_result_i = 32'h0000_0777;
    #2;
    chk("col_c0_adr", rf_wradr_o, 7);
    chk("col_c0_dat", rf_wrdat_o, 32'h0000_0777);
    chk("col_c0_ack", spr_gpr_ack_o, 0);
    tick(); wb_rf_we_i = 0; #2;
    chk("col_c1_we", rf_we_o, 1);
    chk("col_c1_adr", rf_wradr_o, 3);
    chk("col_c1_dat", rf_wrdat_o, 32'hDEADBEEF);
    chk("col_c1_ack", spr_gpr_ack_o, 1);
    tick(); #2;
    chk("col_c2_we", rf_we_o, 0);
    chk("col_c2_ack", spr_gpr_ack_o, 0);
    tick(); bus_idle();

    // Non-GPR SPR write: nothing happens.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 1; spr_bus_addr_i = 16'h0011; spr_bus_dat_i = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("nongpr_ack", spr_gpr_ack_o, 0);
      chk("nongpr_we", rf_we_o, 0);
      tick();
    end
    bus_idle();

    // Read colliding with WB retries; WB during read ack still writes.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 0; spr_bus_addr_i = 16'h0402;
    wb_rf_we_i = 1; wb_rfd_adr_i = 5'd1; wb_result_i = 32'h0000_0101;
    #2;
    chk("rdcol_rd0", spr_rd_en_o, 0);
    chk("rdcol_adr0", rf_wradr_o, 1);
    tick(); wb_rf_we_i = 0; #2;
    chk("rdcol_rd1", spr_rd_en_o, 1);
    chk("rdcol_adr1", rf_wradr_o, 2);
    tick(); wb_rf_we_i = 1; wb_rfd_adr_i = 5'd12; wb_result_i = 32'h0000_0C0C; #2;
    chk("rdcol_ack", spr_gpr_ack_o, 1);
    chk("rdcol_wb_adr", rf_wradr_o, 12);
    tick(); bus_idle();

    // Reset while a write is pending: held data is dropped.
    tick();
    spr_bus_stb_i = 1; spr_bus_we_i = 1; spr_bus_addr_i = 16'h0409; spr_bus_dat_i = 32'hCAFEF00D;
    wb_rf_we_i = 1; wb_rfd_adr_i = 5'd9; wb_result_i = 32'h0000_0999;
    tick(); bus_idle(); rst = 1; #2;
    chk("wpend_rst_we", rf_we_o, 0);
    chk("wpend_rst_ack", spr_gpr_ack_o, 0);
    tick(); rst = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      chk("wpend_no_held_write", rf_we_o && (rf_wrdat_o == 32'hCAFEF00D), 0);
      chk("wpend_no_ack", spr_gpr_ack_o, 0);
      tick();
    end

    // Reset during the read-ack cycle: ack is abandoned.
    spr_bus_stb_i = 1; spr_bus_we_i = 0; spr_bus_addr_i = 16'h0404;
    #2;
    chk("rdrst_rd_en", spr_rd_en_o, 1);
    tick(); rst = 1; #2;
    chk("rdrst_ack", spr_gpr_ack_o, 0);
    tick(); rst = 0; bus_idle();
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("rdrst_no_ack", spr_gpr_ack_o, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
